psc_timer: RTL and testbench

PSC_TIMER -- requirements
Module: psc_timer

---
 rtl/psc_timer_pkg.sv | 20 ++
 rtl/edge_sync.sv | 45 ++++
 rtl/psc_timer.sv | 152 +++++++++++++++
 tb/tb_psc_timer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psc_timer_pkg.sv
// Purpose: shared types and constants for the prescaled compare timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psc_timer_pkg;

    // Default counter / compare width in bits.
    localparam int DEFAULT_WIDTH = 32;

    // Values of the mode input, sampled whenever the counter matches.
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // Timer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : psc_timer_pkg

// File: rtl/edge_sync.sv
// Purpose: two-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
// Latency: pulse is high in the cycle after the second posedge that sees din high.
// Backpressure: none; every synchronised rising edge produces exactly one pulse.
//
// Ports:
//   clk   - sampling clock
//   rst   - asynchronous active-high reset; clears every flop
//   din   - asynchronous input level
//   pulse - one clk-cycle pulse per rising edge of din (sync2 & ~sync3)
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic sync3;
    logic started;  // set on the first posedge after reset
    logic armed;    // set once din has been seen low after reset

    // Until armed, sync3 is loaded from sync1 together with sync2, so a level
    // that is already high when reset releases never looks like a rising edge.
    // Arming needs a low sample taken after the first post-reset posedge,
    // because the reset value of sync1 (0) says nothing about din.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
            started <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sync1   <= din;
            sync2   <= sync1;
            sync3   <= armed ? sync2 : sync1;
            started <= 1'b1;
            armed   <= armed | (started & ~sync1);
        end
    end

    assign pulse = sync2 & ~sync3;

endmodule : edge_sync

// File: rtl/psc_timer.sv
// Purpose: compare timer counting prescaled ticks (hzX edges or every clk in bypass), one-shot or periodic, sticky irq.
// Latency: count steps on the 3rd posedge after hzX is first sampled high; 0 extra cycles in bypass.
// Backpressure: none; ticks arriving in IDLE or DONE are dropped.
//
// Ports:
//   clk, rst             - clock and asynchronous active-high reset
//   hzX                  - prescaled clock, asynchronous to clk
//   psc_bypass           - tick every clk cycle, hzX ignored
//   en                   - enable level; low forces IDLE and clears count
//   mode                 - 0 one-shot, 1 periodic (sampled at each match)
//   cmp_wr, cmp_data     - compare register write
//   clr_irq              - interrupt clear strobe (a same-cycle set wins)
//   count, irq, busy     - registered count, sticky interrupt, RUN indicator
//   cap_in, cap_val      - only with PSC_TIMER_CAPTURE_EN: async capture strobe and
//                          the count latched on each cap_in rising edge
module psc_timer
    import psc_timer_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] CMP_RST = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hzX,
    input  logic             psc_bypass,
    input  logic             en,
    input  logic             mode,
    input  logic             cmp_wr,
    input  logic [WIDTH-1:0] cmp_data,
    input  logic             clr_irq,
`ifdef PSC_TIMER_CAPTURE_EN
    input  logic             cap_in,
    output logic [WIDTH-1:0] cap_val,
`endif
    output logic [WIDTH-1:0] count,
    output logic             irq,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] cmp_q;
    logic             irq_q;
    logic             set_irq;
    logic             hz_pulse;
    logic             tick;

    edge_sync u_hz_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (hzX),
        .pulse (hz_pulse)
    );

    // Bypass skips the synchroniser entirely so a zero-limit prescaler still
    // advances the timer once per clk.
    assign tick = psc_bypass | hz_pulse;

    // Next-state and count logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        set_irq = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    if (count_q == cmp_q) begin
                        set_irq = 1'b1;
                        if (mode == MODE_ONESHOT) begin
                            state_d = DONE;
                        end else begin
                            count_d = '0;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
        // Disable dominates: a match in the same cycle is discarded.
        if (!en) begin
            state_d = IDLE;
            count_d = '0;
            set_irq = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            cmp_q   <= CMP_RST;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            // Matching uses the registered compare, so a write takes effect
            // for matching one cycle later.
            if (cmp_wr) begin
                cmp_q <= cmp_data;
            end
            if (set_irq) begin
                irq_q <= 1'b1;
            end else if (clr_irq) begin
                irq_q <= 1'b0;
            end
        end
    end

`ifdef PSC_TIMER_CAPTURE_EN
    logic             cap_pulse;
    logic [WIDTH-1:0] cap_q;

    edge_sync u_cap_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (cap_in),
        .pulse (cap_pulse)
    );

    // Latches the registered count, i.e. the value before any same-cycle update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q <= '0;
        end else if (cap_pulse) begin
            cap_q <= count_q;
        end
    end

    assign cap_val = cap_q;
`endif

    assign count = count_q;
    assign irq   = irq_q;
    assign busy  = (state_q == RUN);

endmodule : psc_timer

// File: tb/tb_psc_timer.sv
// Purpose: self-checking bench for psc_timer (WIDTH=8): directed scenarios plus randomized runs vs. a tick-count model.
// Latency: inputs change 1 time unit after posedge; outputs are sampled 1 time unit after posedge.
// Backpressure: n/a.
module tb_psc_timer;
    import psc_timer_pkg::*;

    localparam int W = 8;

    logic         clk        = 1'b0;
    logic         rst        = 1'b1;
    logic         hzX        = 1'b0;
    logic         psc_bypass = 1'b0;
    logic         en         = 1'b0;
    logic         mode       = 1'b0;
    logic         cmp_wr     = 1'b0;
    logic [W-1:0] cmp_data   = '0;
    logic         clr_irq    = 1'b0;
    logic [W-1:0] count;
    logic         irq;
    logic         busy;
`ifdef PSC_TIMER_CAPTURE_EN
    logic         cap_in     = 1'b0;
    logic [W-1:0] cap_val;
`endif

    int checks = 0;
    int errors = 0;

    psc_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .hzX        (hzX),
        .psc_bypass (psc_bypass),
        .en         (en),
        .mode       (mode),
        .cmp_wr     (cmp_wr),
        .cmp_data   (cmp_data),
        .clr_irq    (clr_irq),
`ifdef PSC_TIMER_CAPTURE_EN
        .cap_in     (cap_in),
        .cap_val    (cap_val),
`endif
        .count      (count),
        .irq        (irq),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_cmp(input logic [W-1:0] v);
        cmp_data = v;
        cmp_wr   = 1'b1;
        step();
        cmp_wr   = 1'b0;
    endtask

    task automatic go_idle();
        en      = 1'b0;
        clr_irq = 1'b1;
        step();
        clr_irq = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        int c;
        int m;
        int n;
        int k;
        int b;
        int exp_c;
        int exp_i;
        int exp_b;

        // ---------------- reset state ----------------
        step();
        chk("rst_count", count, 0);
        chk("rst_irq", irq, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();
        step();

        // ---------------- one-shot, bypass, cmp=5 ----------------
        write_cmp(8'd5);
        mode       = MODE_ONESHOT;
        psc_bypass = 1'b1;
        en         = 1'b1;
        step();
        chk("os_run_busy", busy, 1);
        chk("os_run_count", count, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("os_count", count, i);
            chk("os_irq_low", irq, 0);
        end
        step();
        chk("os_irq", irq, 1);
        chk("os_hold5", count, 5);
        chk("os_busy_done", busy, 0);
        repeat (3) step();
        chk("os_done_hold", count, 5);

        // en=0 leaves irq alone
        en = 1'b0;
        step();
        chk("dis_count", count, 0);
        chk("dis_irq_kept", irq, 1);
        chk("dis_busy", busy, 0);
        clr_irq = 1'b1;
        step();
        clr_irq = 1'b0;
        chk("clr_irq", irq, 0);

        // ---------------- irq set/clear race ----------------
        write_cmp(8'd2);
        mode = MODE_PERIODIC;
        en   = 1'b1;
        step();
        step();
        step();
        chk("race_pre", count, 2);
        clr_irq = 1'b1;
        step();
        chk("race_set_wins", irq, 1);
        chk("race_wrap", count, 0);
        step();
        clr_irq = 1'b0;
        chk("race_clear", irq, 0);

        // ---------------- periodic via hzX ----------------
        psc_bypass = 1'b0;
        go_idle();
        write_cmp(8'd3);
        mode = MODE_PERIODIC;
        en   = 1'b1;
        step();
        exp_cnt = 0;
        for (int r = 1; r <= 5; r++) begin
            hzX = 1'b1;
            step();
            step();
            chk("per_hold", count, exp_cnt);
            step();
            exp_cnt = (exp_cnt == 3) ? 0 : exp_cnt + 1;
            chk("per_step", count, exp_cnt);
            if (r == 3) chk("per_irq_low", irq, 0);
            if (r == 4) chk("per_irq", irq, 1);
            step();
            hzX = 1'b0;
            repeat (4) step();
        end

        // ---------------- wrap: count 10, cmp 4 ----------------
        go_idle();
        write_cmp(8'd20);
        mode       = MODE_ONESHOT;
        psc_bypass = 1'b1;
        en         = 1'b1;
        step();
        repeat (10) step();
        chk("wrap_start", count, 10);
        psc_bypass = 1'b0;
        write_cmp(8'd4);
        chk("wrap_wr_hold", count, 10);
        psc_bypass = 1'b1;
        for (int i = 1; i <= 250; i++) begin
            step();
            chk("wrap_count", count, (10 + i) % 256);
        end
        chk("wrap_irq_low", irq, 0);
        step();
        chk("wrap_irq", irq, 1);
        chk("wrap_hold", count, 4);
        chk("wrap_busy", busy, 0);

        // ---------------- reset mid-run with hzX held high ----------------
        en = 1'b0;
        step();
        write_cmp(8'd20);
        en = 1'b1;
        step();
        repeat (7) step();
        chk("mid_count7", count, 7);
        chk("mid_irq_before", irq, 1);
        psc_bypass = 1'b0;
        hzX        = 1'b1;
        step();
        rst = 1'b1;
        #2;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        step();
        chk("mid_run_again", busy, 1);
        repeat (5) step();
        chk("mid_no_spurious", count, 0);
        hzX = 1'b0;
        repeat (4) step();
        hzX = 1'b1;
        step();
        step();
        chk("mid_pre_tick", count, 0);
        step();
        chk("mid_tick", count, 1);
        hzX = 1'b0;
        repeat (4) step();

`ifdef PSC_TIMER_CAPTURE_EN
        // ---------------- capture ----------------
        go_idle();
        write_cmp(8'd20);
        psc_bypass = 1'b1;
        en         = 1'b1;
        step();
        repeat (9) step();
        psc_bypass = 1'b0;
        cap_in     = 1'b1;
        step();
        step();
        step();
        chk("cap_val", cap_val, 9);
        cap_in = 1'b0;
        repeat (3) step();
`endif

        // ---------------- randomized runs vs. tick-count model ----------------
        // After k ticks in RUN with compare C: one-shot shows min(k,C) and stops
        // once k exceeds C; periodic shows k mod (C+1); irq is set iff k > C.
        for (int t = 0; t < 25; t++) begin
            c = (t == 0) ? 0 : int'($urandom_range(0, 12));
            m = int'($urandom_range(0, 1));
            n = int'($urandom_range(5, 40));
            psc_bypass = 1'b0;
            go_idle();
            write_cmp(c[W-1:0]);
            mode = m[0];
            en   = 1'b1;
            step();
            k = 0;
            for (int j = 0; j < n; j++) begin
                b = int'($urandom_range(0, 1));
                psc_bypass = b[0];
                step();
                k += b;
            end
            psc_bypass = 1'b0;
            if (m == 1) begin
                exp_c = k % (c + 1);
                exp_b = 1;
            end else begin
                exp_c = (k <= c) ? k : c;
                exp_b = (k <= c) ? 1 : 0;
            end
            exp_i = (k > c) ? 1 : 0;
            chk("rnd_count", count, exp_c);
            chk("rnd_irq", irq, exp_i);
            chk("rnd_busy", busy, exp_b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_psc_timer
